regfile_ctrl_seq: RTL and testbench

//  Multi-cycle instruction sequencer that drives the 8x16 register file's control side.

---
 rtl/regfile_ctrl_seq_pkg.sv | 54 +++++
 rtl/regfile_ctrl_seq_if.sv | 20 ++
 rtl/regfile_ctrl_seq_instr_decoder.sv | 31 +++
 rtl/regfile_ctrl_seq.sv | 171 +++++++++++++++++
 tb/tb_regfile_ctrl_seq.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_ctrl_seq_pkg.sv
// Shared opcodes, FSM state encoding, instruction field positions and decode class
// for the register-file control sequencer.
package regfile_ctrl_seq_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_ADC   = 4'h3;
    localparam logic [3:0] OP_SBB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOT   = 4'h8;
    localparam logic [3:0] OP_SHL   = 4'h9;
    localparam logic [3:0] OP_SHR   = 4'hA;
    localparam logic [3:0] OP_MOVI  = 4'hB;
    localparam logic [3:0] OP_LOAD  = 4'hC;
    localparam logic [3:0] OP_STORE = 4'hD;
    localparam logic [3:0] OP_RSVD  = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;
    localparam int HI_BIT  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic alu;
        logic flag_op;
        logic movi;
        logic load;
        logic store;
        logic nop;
        logic halt;
        logic illegal;
    } instr_class_t;

endpackage

// File: rtl/regfile_ctrl_seq_if.sv
// Instruction-fetch handshake and data-memory request bus of the sequencer.
// master = fetch/memory side, slave = sequencer.
interface regfile_ctrl_seq_if;
    logic [15:0] instr_pi;
    logic        instr_valid_pi;
    logic        instr_ready_po;
    logic        mem_req_po;
    logic        mem_we_po;
    logic        mem_ack_pi;

    modport master (
        output instr_pi, instr_valid_pi, mem_ack_pi,
        input  instr_ready_po, mem_req_po, mem_we_po
    );

    modport slave (
        input  instr_pi, instr_valid_pi, mem_ack_pi,
        output instr_ready_po, mem_req_po, mem_we_po
    );
endinterface

// File: rtl/regfile_ctrl_seq_instr_decoder.sv
// Combinational opcode classifier. With ILLEGAL_TRAP_EN defined the reserved
// opcode is flagged illegal, otherwise it is treated as a NOP.
module instr_decoder
    import regfile_ctrl_seq_pkg::*;
(
    input  logic [3:0]   op,
    output instr_class_t cls
);

    always_comb begin
        cls = '0;
        case (op)
            OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
                cls.alu     = 1'b1;
                cls.flag_op = 1'b1;
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR: cls.alu = 1'b1;
            OP_MOVI:  cls.movi  = 1'b1;
            OP_LOAD:  cls.load  = 1'b1;
            OP_STORE: cls.store = 1'b1;
            OP_HALT:  cls.halt  = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            OP_RSVD:  cls.illegal = 1'b1;
`else
            OP_RSVD:  cls.nop     = 1'b1;
`endif
            default:  cls.nop   = 1'b1;
        endcase
    end

endmodule

// File: rtl/regfile_ctrl_seq.sv
// Multi-cycle instruction sequencer for the 8x16 regfile; optional ILLEGAL_TRAP_EN traps opcode E.
// States: FETCH accept | DECODE classify | EXEC alu | MEM wait ack | WB strobes | HALT stop
module regfile_ctrl_seq
    import regfile_ctrl_seq_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk_pi,
    input  logic                 reset_pi,
    input  logic                 clk_en_pi,
    regfile_ctrl_seq_if.slave    bus_if,
    output logic [2:0]           source_reg1_po,
    output logic [2:0]           source_reg2_po,
    output logic [2:0]           destination_reg_po,
    output logic                 wr_destination_reg_po,
    output logic                 movi_lower_po,
    output logic                 movi_higher_po,
    output logic [7:0]           immediate_po,
    output logic [3:0]           alu_op_po,
    output logic                 flag_update_po,
    output logic                 wb_sel_po,
    output logic [PC_W-1:0]      pc_po,
    output logic [CNT_W-1:0]     retire_cnt_po,
    output logic                 halted_po,
    output logic                 illegal_po
);

    state_t            state;
    logic [15:0]       instr_q;
    instr_class_t      cls;
    logic              ready_q;
    logic              wr_q;
    logic              movi_lo_q;
    logic              movi_hi_q;
    logic              flag_q;
    logic              wb_sel_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic              halted_q;
    logic [PC_W-1:0]   pc_q;
    logic [CNT_W-1:0]  cnt_q;

    instr_decoder u_dec (
        .op  (instr_q[OP_MSB:OP_LSB]),
        .cls (cls)
    );

    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            state     <= ST_FETCH;
            instr_q   <= '0;
            ready_q   <= 1'b1;
            wr_q      <= 1'b0;
            movi_lo_q <= 1'b0;
            movi_hi_q <= 1'b0;
            flag_q    <= 1'b0;
            wb_sel_q  <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            halted_q  <= 1'b0;
            pc_q      <= '0;
            cnt_q     <= '0;
        end else if (clk_en_pi) begin
            // WB strobes live for exactly one enabled cycle
            wr_q      <= 1'b0;
            movi_lo_q <= 1'b0;
            movi_hi_q <= 1'b0;
            flag_q    <= 1'b0;
            wb_sel_q  <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (bus_if.instr_valid_pi && ready_q) begin
                        instr_q <= bus_if.instr_pi;
                        ready_q <= 1'b0;
                        state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (cls.halt) begin
                        state    <= ST_HALT;
                        halted_q <= 1'b1;
                        pc_q     <= pc_q + 1'b1;
                        cnt_q    <= cnt_q + 1'b1;
                    end else if (cls.illegal) begin
                        state    <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (cls.nop) begin
                        state   <= ST_FETCH;
                        ready_q <= 1'b1;
                        pc_q    <= pc_q + 1'b1;
                        cnt_q   <= cnt_q + 1'b1;
                    end else if (cls.movi) begin
                        state     <= ST_WB;
                        movi_hi_q <= instr_q[HI_BIT];
                        movi_lo_q <= ~instr_q[HI_BIT];
                    end else if (cls.load || cls.store) begin
                        state     <= ST_MEM;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= cls.store;
                    end else begin
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state  <= ST_WB;
                    wr_q   <= 1'b1;
                    flag_q <= cls.flag_op;
                end
                ST_MEM: begin
                    if (bus_if.mem_ack_pi) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (cls.store) begin
                            state   <= ST_FETCH;
                            ready_q <= 1'b1;
                            pc_q    <= pc_q + 1'b1;
                            cnt_q   <= cnt_q + 1'b1;
                        end else begin
                            state    <= ST_WB;
                            wr_q     <= 1'b1;
                            wb_sel_q <= 1'b1;
                        end
                    end
                end
                ST_WB: begin
                    state   <= ST_FETCH;
                    ready_q <= 1'b1;
                    pc_q    <= pc_q + 1'b1;
                    cnt_q   <= cnt_q + 1'b1;
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_FETCH;
            endcase
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk_pi) begin
        if (reset_pi)
            illegal_q <= 1'b0;
        else if (clk_en_pi && state == ST_DECODE && cls.illegal)
            illegal_q <= 1'b1;
    end

    assign illegal_po = illegal_q;
`else
    assign illegal_po = 1'b0;
`endif

    assign bus_if.instr_ready_po = ready_q;
    assign bus_if.mem_req_po     = mem_req_q;
    assign bus_if.mem_we_po      = mem_we_q;

    assign source_reg1_po        = instr_q[RS1_MSB:RS1_LSB];
    assign source_reg2_po        = instr_q[RS2_MSB:RS2_LSB];
    assign destination_reg_po    = instr_q[RD_MSB:RD_LSB];
    assign immediate_po          = instr_q[IMM_MSB:IMM_LSB];
    assign alu_op_po             = instr_q[OP_MSB:OP_LSB];
    assign wr_destination_reg_po = wr_q;
    assign movi_lower_po         = movi_lo_q;
    assign movi_higher_po        = movi_hi_q;
    assign flag_update_po        = flag_q;
    assign wb_sel_po             = wb_sel_q;
    assign pc_po                 = pc_q;
    assign retire_cnt_po         = cnt_q;
    assign halted_po             = halted_q;

endmodule

// File: tb/tb_regfile_ctrl_seq.sv
// Scoreboard bench for regfile_ctrl_seq: stimulus queues expected WB/memory events,
// a negedge monitor pops and compares them when the DUT commits.
module tb_regfile_ctrl_seq;

    logic        clk_pi = 1'b0;
    logic        reset_pi;
    logic        clk_en_pi;
    logic [2:0]  source_reg1_po;
    logic [2:0]  source_reg2_po;
    logic [2:0]  destination_reg_po;
    logic        wr_destination_reg_po;
    logic        movi_lower_po;
    logic        movi_higher_po;
    logic [7:0]  immediate_po;
    logic [3:0]  alu_op_po;
    logic        flag_update_po;
    logic        wb_sel_po;
    logic [7:0]  pc_po;
    logic [15:0] retire_cnt_po;
    logic        halted_po;
    logic        illegal_po;

    regfile_ctrl_seq_if bus ();

    regfile_ctrl_seq #(.PC_W(8), .CNT_W(16)) dut (
        .clk_pi                (clk_pi),
        .reset_pi              (reset_pi),
        .clk_en_pi             (clk_en_pi),
        .bus_if                (bus),
        .source_reg1_po        (source_reg1_po),
        .source_reg2_po        (source_reg2_po),
        .destination_reg_po    (destination_reg_po),
        .wr_destination_reg_po (wr_destination_reg_po),
        .movi_lower_po         (movi_lower_po),
        .movi_higher_po        (movi_higher_po),
        .immediate_po          (immediate_po),
        .alu_op_po             (alu_op_po),
        .flag_update_po        (flag_update_po),
        .wb_sel_po             (wb_sel_po),
        .pc_po                 (pc_po),
        .retire_cnt_po         (retire_cnt_po),
        .halted_po             (halted_po),
        .illegal_po            (illegal_po)
    );

    always #5 clk_pi = ~clk_pi;

    int cyc = 0;
    always @(posedge clk_pi) cyc <= cyc + 1;

    typedef struct packed {
        logic       wr;
        logic       mlo;
        logic       mhi;
        logic       flag;
        logic       wbsel;
        logic [2:0] rd;
        logic [7:0] imm;
        logic [3:0] op;
        logic [7:0] lat;
    } wb_exp_t;

    wb_exp_t wb_q[$];
    logic    mem_q[$];
    int      acc_cyc = 0;
    int      n_checks = 0;
    int      n_fail = 0;
    int      ack_delay = 1;
    int      mem_cnt = 0;
    int      mem_req_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_wb(input logic wr, input logic mlo, input logic mhi, input logic flag,
                           input logic wbsel, input logic [2:0] rd, input logic [7:0] imm,
                           input logic [3:0] op, input logic [7:0] lat);
        wb_exp_t e;
        e = '{wr: wr, mlo: mlo, mhi: mhi, flag: flag, wbsel: wbsel, rd: rd, imm: imm, op: op, lat: lat};
        wb_q.push_back(e);
    endtask

    // Memory responder: acks on the ack_delay-th cycle of a held request
    always @(posedge clk_pi) begin
        #1;
        if (bus.mem_req_po === 1'b1) begin
            mem_cnt = mem_cnt + 1;
            bus.mem_ack_pi = (mem_cnt == ack_delay);
            if (mem_cnt == ack_delay) mem_req_cycles = mem_cnt;
        end else begin
            mem_cnt = 0;
            bus.mem_ack_pi = 1'b0;
        end
    end

    always @(negedge clk_pi) begin : monitor
        wb_exp_t e;
        logic    we_exp;
        if (reset_pi === 1'b0 && clk_en_pi === 1'b1) begin
            if (wr_destination_reg_po || movi_lower_po || movi_higher_po) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected_wb", {wr_destination_reg_po, movi_lower_po, movi_higher_po}, 0);
                end else begin
                    e = wb_q.pop_front();
                    chk("wb_strobes", {wr_destination_reg_po, movi_lower_po, movi_higher_po,
                                       flag_update_po, wb_sel_po}, {e.wr, e.mlo, e.mhi, e.flag, e.wbsel});
                    chk("wb_fields", {destination_reg_po, immediate_po, alu_op_po}, {e.rd, e.imm, e.op});
                    chk("wb_latency", 8'(cyc - acc_cyc + 1), e.lat);
                end
            end
            if (bus.mem_req_po && bus.mem_ack_pi) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_mem", 1, 0);
                end else begin
                    we_exp = mem_q.pop_front();
                    chk("mem_we", bus.mem_we_po, we_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_pi);
        #1;
    endtask

    task automatic do_reset();
        reset_pi = 1'b1;
        tick();
        tick();
        reset_pi = 1'b0;
    endtask

    task automatic send(input logic [15:0] ins);
        int n;
        n = 0;
        bus.instr_pi = ins;
        bus.instr_valid_pi = 1'b1;
        while (!(bus.instr_ready_po && clk_en_pi) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("accept_timeout", 1, 0);
        @(posedge clk_pi);
        #1;
        acc_cyc = cyc;
        bus.instr_valid_pi = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.instr_ready_po && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("ready_timeout", 1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_pi = 16'h0000;
        bus.instr_valid_pi = 1'b0;
        clk_en_pi = 1'b1;
        do_reset();

        chk("rst_ready", bus.instr_ready_po, 1);
        chk("rst_pc", pc_po, 0);
        chk("rst_cnt", retire_cnt_po, 0);
        chk("rst_status", {halted_po, illegal_po}, 0);
        chk("rst_strobes", {wr_destination_reg_po, movi_lower_po, movi_higher_po, flag_update_po,
                            wb_sel_po, bus.mem_req_po, bus.mem_we_po}, 0);
        chk("rst_fields", {alu_op_po, destination_reg_po, immediate_po}, 0);

        // ADD r1 <= r2 + r3
        push_wb(1, 0, 0, 1, 0, 3'd1, 8'h98, 4'h1, 8'd3);
        send(16'h1298);
        chk("add_srcs", {source_reg1_po, source_reg2_po, destination_reg_po}, {3'd2, 3'd3, 3'd1});
        wait_ready();
        chk("add_pc", pc_po, 1);
        chk("add_cnt", retire_cnt_po, 1);

        // MOVI high byte
        push_wb(0, 0, 1, 0, 0, 3'd2, 8'hAB, 4'hB, 8'd2);
        send(16'hB5AB);
        wait_ready();
        chk("movi_pc", pc_po, 2);

        // LOAD with ack on the 5th request cycle
        ack_delay = 5;
        push_wb(1, 0, 0, 0, 1, 3'd3, 8'h00, 4'hC, 8'd7);
        mem_q.push_back(1'b0);
        send(16'hC600);
        wait_ready();
        chk("load_req_cycles", mem_req_cycles, 5);
        chk("load_cnt", retire_cnt_po, 3);

        // AND: no flag update
        push_wb(1, 0, 0, 0, 0, 3'd7, 8'h38, 4'h5, 8'd3);
        send(16'h5E38);
        wait_ready();
        chk("and_pc", pc_po, 4);

        // NOP: back in FETCH after 2 cycles
        send(16'h0000);
        tick();
        chk("nop_ready", bus.instr_ready_po, 1);
        chk("nop_pc_cnt", {pc_po, retire_cnt_po}, {8'd5, 16'd5});

        // STORE then HALT
        do_reset();
        ack_delay = 1;
        mem_q.push_back(1'b1);
        send(16'hD200);
        wait_ready();
        chk("store_cnt", retire_cnt_po, 1);
        send(16'hF000);
        tick();
        chk("halt_status", {halted_po, bus.instr_ready_po}, 2'b10);
        chk("halt_cnt", retire_cnt_po, 2);
        chk("halt_pc", pc_po, 2);
        bus.instr_pi = 16'h1298;
        bus.instr_valid_pi = 1'b1;
        repeat (5) tick();
        chk("halt_held", {halted_po, bus.instr_ready_po}, 2'b10);
        chk("halt_cnt_held", retire_cnt_po, 2);
        bus.instr_valid_pi = 1'b0;

        // ADC frozen 3 cycles in EXEC
        do_reset();
        push_wb(1, 0, 0, 1, 0, 3'd1, 8'h98, 4'h3, 8'd6);
        send(16'h3298);
        tick();
        clk_en_pi = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("freeze_state", {wr_destination_reg_po, bus.instr_ready_po, pc_po}, 0);
        end
        clk_en_pi = 1'b1;
        wait_ready();
        chk("freeze_pc", pc_po, 1);

        // SUB frozen 2 cycles in WB: strobe holds, write on next enabled edge
        push_wb(1, 0, 0, 1, 0, 3'd1, 8'h98, 4'h2, 8'd5);
        send(16'h2298);
        tick();
        tick();
        clk_en_pi = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("wb_hold", {wr_destination_reg_po, flag_update_po}, 2'b11);
        end
        clk_en_pi = 1'b1;
        wait_ready();
        chk("wb_hold_pc", pc_po, 2);

        // SBB aborted by reset in WB
        send(16'h4298);
        for (int i = 0; i < 10 && !wr_destination_reg_po; i++) tick();
        chk("sbb_reached_wb", wr_destination_reg_po, 1);
        reset_pi = 1'b1;
        tick();
        reset_pi = 1'b0;
        chk("abort_pc_cnt", {pc_po, retire_cnt_po}, 0);
        chk("abort_outputs", {wr_destination_reg_po, flag_update_po, bus.instr_ready_po}, 3'b001);

        // Reserved opcode E
        send(16'hE000);
        tick();
`ifdef ILLEGAL_TRAP_EN
        chk("rsvd_status", {halted_po, illegal_po, bus.instr_ready_po}, 3'b110);
        chk("rsvd_pc_cnt", {pc_po, retire_cnt_po}, 0);
`else
        chk("rsvd_status", {halted_po, illegal_po, bus.instr_ready_po}, 3'b001);
        chk("rsvd_pc_cnt", {pc_po, retire_cnt_po}, {8'd1, 16'd1});
`endif
        tick();
        chk("wb_queue_drained", wb_q.size(), 0);
        chk("mem_queue_drained", mem_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
